// File: rtl/chrom_sched_pkg.sv
// Shared types and default widths for the chromosome evaluation scheduler.
// Optional best tracker is built only with CHROM_SCHED_BEST_TRACK_EN.
package chrom_sched_pkg;
    localparam int DEF_NUM_OUTPUTS = 8;
    localparam int DEF_SUM_W = 32;
    localparam int DEF_IDX_W = 8;
    localparam int FITNESS_W = DEF_SUM_W + 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_DONE,
        REDUCE,
        WRITE,
        ACK,
        FINISH
    } state_t;
endpackage

// File: rtl/chromosome_evaluation_scheduler_if.sv
// Control, engine handshake and fitness-store signals of the scheduler.
// master = scheduler side, slave = GA control / engine / store side.
interface chromosome_evaluation_scheduler_if #(
    parameter int NUM_OUTPUTS = 8,
    parameter int SUM_W = 32,
    parameter int IDX_W = 8
);
    logic                               iStartGeneration;
    logic [IDX_W-1:0]                   iPopulationSize;
    logic [IDX_W-1:0]                   oChromIndex;
    logic                               oStartProcessing;
    logic                               iReadyToProcess;
    logic                               iDoneProcessing;
    logic                               oDoneProcessingFeedback;
    logic [NUM_OUTPUTS-1:0][SUM_W-1:0]  iErrorSums;
    logic                               oFitnessWe;
    logic [IDX_W-1:0]                   oFitnessAddr;
    logic [SUM_W-1:0]                   oFitnessData;
    logic [IDX_W-1:0]                   oBestIndex;
    logic [SUM_W-1:0]                   oBestFitness;
    logic                               oBusy;
    logic                               oGenerationDone;

    modport master (
        input  iStartGeneration, iPopulationSize, iReadyToProcess,
        input  iDoneProcessing, iErrorSums,
        output oChromIndex, oStartProcessing, oDoneProcessingFeedback,
        output oFitnessWe, oFitnessAddr, oFitnessData,
        output oBestIndex, oBestFitness, oBusy, oGenerationDone
    );

    modport slave (
        output iStartGeneration, iPopulationSize, iReadyToProcess,
        output iDoneProcessing, iErrorSums,
        input  oChromIndex, oStartProcessing, oDoneProcessingFeedback,
        input  oFitnessWe, oFitnessAddr, oFitnessData,
        input  oBestIndex, oBestFitness, oBusy, oGenerationDone
    );
endinterface

// File: rtl/chromosome_evaluation_scheduler_fitness_reducer.sv
// Saturating sum of the per-output error sums into one fitness word.
module fitness_reducer
    import chrom_sched_pkg::*;
#(
    parameter int NUM_OUTPUTS = DEF_NUM_OUTPUTS,
    parameter int SUM_W = DEF_SUM_W
) (
    input  logic [NUM_OUTPUTS-1:0][SUM_W-1:0] iErrorSums,
    output logic [SUM_W-1:0]                  oFitness
);
    // three guard bits hold the carry of up to eight full-scale terms
    localparam int ACC_W = SUM_W + 3;

    logic [ACC_W-1:0] total;

    always_comb begin
        total = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++)
            total = total + ACC_W'(iErrorSums[i]);
        oFitness = (total[ACC_W-1:SUM_W] != '0) ? '1 : total[SUM_W-1:0];
    end
endmodule

// File: rtl/chromosome_evaluation_scheduler.sv
// Runs each chromosome of a generation through the engine and scores it.
// Best-candidate tracking is built only with CHROM_SCHED_BEST_TRACK_EN.
module chromosome_evaluation_scheduler
    import chrom_sched_pkg::*;
#(
    parameter int NUM_OUTPUTS = DEF_NUM_OUTPUTS,
    parameter int SUM_W = DEF_SUM_W,
    parameter int IDX_W = DEF_IDX_W
) (
    input logic iClock,
    input logic iReset,
    chromosome_evaluation_scheduler_if.master bus
);
    state_t           state;
    logic [IDX_W-1:0] index;
    logic [IDX_W-1:0] size;
    logic [SUM_W-1:0] fitness;
    logic [SUM_W-1:0] reduced;
    logic             genDone;
    logic             newGen;

    fitness_reducer #(
        .NUM_OUTPUTS(NUM_OUTPUTS),
        .SUM_W(SUM_W)
    ) uReducer (
        .iErrorSums(bus.iErrorSums),
        .oFitness(reduced)
    );

    assign newGen = (state == IDLE) && bus.iStartGeneration &&
                    (bus.iPopulationSize != '0);

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state   <= IDLE;
            index   <= '0;
            size    <= '0;
            fitness <= '0;
            genDone <= 1'b0;
        end else begin
            genDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.iStartGeneration) begin
                        if (bus.iPopulationSize != '0) begin
                            size  <= bus.iPopulationSize;
                            index <= '0;
                            state <= LOAD;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end
                LOAD: state <= START;
                START: if (bus.iReadyToProcess) state <= WAIT_DONE;
                WAIT_DONE: if (bus.iDoneProcessing) state <= REDUCE;
                REDUCE: begin
                    fitness <= reduced;
                    state   <= WRITE;
                end
                WRITE: state <= ACK;
                ACK: begin
                    if (!bus.iDoneProcessing) begin
                        if (index == size - IDX_W'(1)) begin
                            state <= FINISH;
                        end else begin
                            index <= index + IDX_W'(1);
                            state <= LOAD;
                        end
                    end
                end
                FINISH: begin
                    genDone <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // engine handshake decodes straight off the state so reset drops it at once
    assign bus.oStartProcessing = (state == START) && bus.iReadyToProcess;
    assign bus.oDoneProcessingFeedback = (state == ACK);
    assign bus.oFitnessWe = (state == WRITE);
    assign bus.oBusy = (state != IDLE);
    assign bus.oChromIndex = index;
    assign bus.oFitnessAddr = index;
    assign bus.oFitnessData = fitness;
    assign bus.oGenerationDone = genDone;

`ifdef CHROM_SCHED_BEST_TRACK_EN
    logic [IDX_W-1:0] bestIndex;
    logic [SUM_W-1:0] bestFitness;

    // strict compare keeps the earlier (lower) index on ties
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            bestIndex   <= '0;
            bestFitness <= '1;
        end else if (newGen) begin
            bestIndex   <= '0;
            bestFitness <= '1;
        end else if (state == WRITE && fitness < bestFitness) begin
            bestIndex   <= index;
            bestFitness <= fitness;
        end
    end

    assign bus.oBestIndex = bestIndex;
    assign bus.oBestFitness = bestFitness;
`else
    logic unusedNewGen;
    assign unusedNewGen = newGen;
    assign bus.oBestIndex = '0;
    assign bus.oBestFitness = '1;
`endif
endmodule

// File: tb/tb_chromosome_evaluation_scheduler.sv
// Self-checking bench: engine model plus arithmetic reference for fitness/best.
module tb_chromosome_evaluation_scheduler;
    import chrom_sched_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    chromosome_evaluation_scheduler_if bus ();

    chromosome_evaluation_scheduler dut (
        .iClock(clk),
        .iReset(rst),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0][31:0] genSums [16];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] refFit(input logic [7:0][31:0] s);
        longint unsigned t;
        t = 0;
        for (int i = 0; i < 8; i++) t += longint'(s[i]);
        if (t > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
        return t[31:0];
    endfunction

    function automatic logic [31:0] randSum();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 7));
            1: return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            2: return $urandom;
            default: return 32'h0;
        endcase
    endfunction

    task automatic checkBest(input logic [7:0] bi, input logic [31:0] bf);
`ifdef CHROM_SCHED_BEST_TRACK_EN
        chk("best_idx", bus.oBestIndex, bi);
        chk("best_fit", bus.oBestFitness, bf);
`else
        chk("best_idx_tie", bus.oBestIndex, 0);
        chk("best_fit_tie", bus.oBestFitness, 32'hFFFF_FFFF);
        if (bi == 8'hFF && bf == 0) $display("unreachable");
`endif
    endtask

    task automatic acceptStart(input int c, input int delay);
        int g;
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            chk("start_low", bus.oStartProcessing, 0);
        end
        bus.iReadyToProcess = 1'b1;
        #1;
        g = 0;
        while (!bus.oStartProcessing && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("start_req", bus.oStartProcessing, 1);
        chk("chrom_idx", bus.oChromIndex, c);
        @(negedge clk);
        chk("start_once", bus.oStartProcessing, 0);
        bus.iReadyToProcess = 1'b0;
    endtask

    task automatic runGen(input int n, input int firstDelay);
        logic [31:0] f, bestF;
        logic [7:0] bestI;
        int g;
        bestF = '1;
        bestI = '0;
        @(negedge clk);
        bus.iPopulationSize = 8'(n);
        bus.iStartGeneration = 1'b1;
        @(negedge clk);
        bus.iStartGeneration = 1'b0;
        bus.iPopulationSize = 8'($urandom_range(0, 255));
        chk("busy_rise", bus.oBusy, 1);
        for (int c = 0; c < n; c++) begin
            acceptStart(c, (c == 0) ? firstDelay : $urandom_range(1, 3));
            repeat ($urandom_range(0, 4)) @(negedge clk);
            bus.iErrorSums = genSums[c];
            bus.iDoneProcessing = 1'b1;
            f = refFit(genSums[c]);
            g = 0;
            while (!bus.oFitnessWe && g < 20) begin
                @(negedge clk);
                g++;
            end
            chk("we", bus.oFitnessWe, 1);
            chk("addr", bus.oFitnessAddr, c);
            chk("data", bus.oFitnessData, f);
            if (f < bestF) begin
                bestF = f;
                bestI = 8'(c);
            end
            @(negedge clk);
            chk("we_pulse", bus.oFitnessWe, 0);
            chk("fb_high", bus.oDoneProcessingFeedback, 1);
            checkBest(bestI, bestF);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("fb_hold", bus.oDoneProcessingFeedback, 1);
            end
            bus.iDoneProcessing = 1'b0;
            for (int i = 0; i < 8; i++) bus.iErrorSums[i] = $urandom;
            @(negedge clk);
            chk("fb_low", bus.oDoneProcessingFeedback, 0);
            chk("gen_early", bus.oGenerationDone, 0);
        end
        g = 0;
        while (!bus.oGenerationDone && g < 10) begin
            @(negedge clk);
            g++;
        end
        chk("gen_done", bus.oGenerationDone, 1);
        chk("gen_done_lat", g, 1);
        chk("busy_fall", bus.oBusy, 0);
        @(negedge clk);
        chk("gen_pulse", bus.oGenerationDone, 0);
        checkBest(bestI, bestF);
    endtask

    initial begin
        rst = 1'b1;
        bus.iStartGeneration = 1'b0;
        bus.iPopulationSize = '0;
        bus.iReadyToProcess = 1'b0;
        bus.iDoneProcessing = 1'b0;
        bus.iErrorSums = '0;
        #1;
        chk("rst_busy", bus.oBusy, 0);
        chk("rst_start", bus.oStartProcessing, 0);
        chk("rst_fb", bus.oDoneProcessingFeedback, 0);
        chk("rst_we", bus.oFitnessWe, 0);
        chk("rst_data", bus.oFitnessData, 0);
        chk("rst_idx", bus.oChromIndex, 0);
        chk("rst_gdone", bus.oGenerationDone, 0);
        chk("rst_bidx", bus.oBestIndex, 0);
        chk("rst_bfit", bus.oBestFitness, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // basic generation
        genSums[0] = '0; genSums[0][0] = 32'd1;
        genSums[1] = '0;
        genSums[2] = '0; genSums[2][0] = 32'd2; genSums[2][1] = 32'd2;
        runGen(3, 1);

        // reset while the engine is working on chromosome 0
        for (int i = 0; i < 2; i++) genSums[i] = '0;
        @(negedge clk);
        bus.iPopulationSize = 8'd2;
        bus.iStartGeneration = 1'b1;
        @(negedge clk);
        bus.iStartGeneration = 1'b0;
        acceptStart(0, 1);
        bus.iReadyToProcess = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_busy", bus.oBusy, 0);
        chk("mrst_start", bus.oStartProcessing, 0);
        chk("mrst_fb", bus.oDoneProcessingFeedback, 0);
        chk("mrst_data", bus.oFitnessData, 0);
        chk("mrst_bidx", bus.oBestIndex, 0);
        chk("mrst_bfit", bus.oBestFitness, 32'hFFFF_FFFF);
        @(negedge clk);
        rst = 1'b0;
        bus.iReadyToProcess = 1'b0;
        genSums[0] = '0; genSums[0][3] = 32'd9;
        runGen(1, 1);

        // saturation
        for (int i = 0; i < 8; i++) genSums[0][i] = 32'hFFFF_FFF0;
        runGen(1, 2);

        // tie keeps the lower index
        genSums[0] = '0; genSums[0][0] = 32'd5;
        genSums[1] = '0; genSums[1][6] = 32'd3; genSums[1][7] = 32'd2;
        runGen(2, 1);

        // engine not ready for ten cycles
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 8; i++) genSums[c][i] = randSum();
        runGen(2, 10);

        // zero-size generation
        @(negedge clk);
        bus.iReadyToProcess = 1'b1;
        bus.iPopulationSize = '0;
        bus.iStartGeneration = 1'b1;
        @(negedge clk);
        bus.iStartGeneration = 1'b0;
        chk("z_busy", bus.oBusy, 1);
        chk("z_start", bus.oStartProcessing, 0);
        chk("z_gdone0", bus.oGenerationDone, 0);
        @(negedge clk);
        chk("z_gdone", bus.oGenerationDone, 1);
        chk("z_busy_fall", bus.oBusy, 0);
        chk("z_start2", bus.oStartProcessing, 0);
        @(negedge clk);
        chk("z_pulse", bus.oGenerationDone, 0);
        bus.iReadyToProcess = 1'b0;

        // randomized generations
        for (int r = 0; r < 10; r++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int c = 0; c < n; c++)
                for (int i = 0; i < 8; i++) genSums[c][i] = randSum();
            runGen(n, $urandom_range(1, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
